// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, byte framing constants and the
// line-event bundle produced by i2c_line_sync (also used by i2c_master).
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } state_e;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    // Level of a released open-drain line; synchronizers reset to it so that
    // leaving reset never fabricates a START or STOP.
    localparam logic LINE_IDLE = 1'b1;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } line_evt_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with one extra registered copy for edge detection;
// reports SCL edges and START/STOP conditions as single-cycle events.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      scl_in,
    input  logic      sda_in,
    output logic      sda,
    output line_evt_t evt
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= {SYNC_STAGES{LINE_IDLE}};
            sda_sync_q <= {SYNC_STAGES{LINE_IDLE}};
            scl_prev_q <= LINE_IDLE;
            sda_prev_q <= LINE_IDLE;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl = scl_sync_q[SYNC_STAGES-1];
    assign sda = sda_sync_q[SYNC_STAGES-1];

    // START/STOP require SCL high in both samples so an SDA change that races
    // an SCL edge is never misread as a bus condition.
    always_comb begin
        evt.scl_rise = scl & ~scl_prev_q;
        evt.scl_fall = ~scl & scl_prev_q;
        evt.start    = scl & scl_prev_q & sda_prev_q & ~sda;
        evt.stop     = scl & scl_prev_q & ~sda_prev_q & sda;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write-byte delivery and read-byte serving over an
// oversampled open-drain bus, with a host-side byte interface.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h44,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw,
    output logic       stop_seen
);

    logic      sda;
    line_evt_t evt;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       stop_seen_q, stop_seen_d;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk    (clk),
        .rst    (rst),
        .scl_in (scl_in),
        .sda_in (sda_in),
        .sda    (sda),
        .evt    (evt)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy_q;
        rw_d        = rw_q;
        stop_seen_d = 1'b0;

        if (evt.stop) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_seen_d = 1'b1;
        end else if (evt.start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (evt.scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (evt.scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            rw_d     = shift_q[0];
                            busy_d   = 1'b1;
                            sda_oe_d = 1'b1;
                            tx_req_d = shift_q[0];
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // Also re-entered after a master ACK in READ_ACK: the fall that
                // ends an ACK slot loads the next read byte the same way.
                ST_ADDR_ACK: begin
                    if (evt.scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        if (rw_q) begin
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_READ;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (evt.scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            rx_data_d  = {shift_q[6:0], sda};
                            rx_valid_d = 1'b1;
                        end
                    end else if (evt.scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = ack_en;
                        state_d   = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: begin
                    if (evt.scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (evt.scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (evt.scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            state_d   = ST_READ_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (evt.scl_rise) begin
                        if (!sda) begin
                            tx_req_d = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sda_oe_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign rw        = rw_q;
    assign stop_seen = stop_seen_q;

endmodule
